// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, operand shift registers
// and a bit counter. Adds LSB-first, one bit per clock, and presents parallel and serial results.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ cin;
    assign co = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             s_bit,
    output logic             s_valid
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_out_q, carry_out_d;
    logic             s_bit_q, s_bit_d;
    logic             s_valid_q, s_valid_d;
    logic             fa_s, fa_co;

    full_adder u_fa (
        .x   (a_q[0]),
        .y   (b_q[0]),
        .cin (c_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Next-state and datapath; IDLE and DONE both accept a new start
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        carry_out_d = carry_out_q;
        s_bit_d     = 1'b0;
        s_valid_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d         = a;
                    b_d         = b;
                    c_d         = ci;
                    cnt_d       = '0;
                    sum_d       = '0;
                    carry_out_d = 1'b0;
                    state_d     = S_ADD;
                end
            end
            S_ADD: begin
                a_d       = a_q >> 1;
                b_d       = b_q >> 1;
                sum_d     = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                c_d       = fa_co;
                s_bit_d   = fa_s;
                s_valid_d = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    carry_out_d = fa_co;
                    state_d     = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            carry_out_q <= 1'b0;
            s_bit_q     <= 1'b0;
            s_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            carry_out_q <= carry_out_d;
            s_bit_q     <= s_bit_d;
            s_valid_q   <= s_valid_d;
        end
    end

    assign busy      = (state_q == S_ADD);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign s_bit     = s_bit_q;
    assign s_valid   = s_valid_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for timing/serial checks and
// a 3-bit instance swept exhaustively.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, ci8, busy8, done8, co8, s_bit8, s_valid8;
    logic [7:0] a8, b8, sum8;

    logic       start3, ci3, busy3, done3, co3, s_bit3, s_valid3;
    logic [2:0] a3, b3, sum3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8),
        .s_bit(s_bit8), .s_valid(s_valid8)
    );

    serial_adder #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .ci(ci3),
        .busy(busy3), .done(done3), .sum(sum3), .carry_out(co3),
        .s_bit(s_bit3), .s_valid(s_valid3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation from the current cycle; returns with the DUT in its DONE cycle
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic civ,
                       input logic [7:0] exp_sum, input logic exp_co, input string tag);
        int n, busy_n, nbits;
        logic [15:0] bits;
        n = 0; busy_n = 0; nbits = 0; bits = '0;
        a8 = av; b8 = bv; ci8 = civ; start8 = 1'b1;
        step();
        start8 = 1'b0;
        while (done8 !== 1'b1 && n < 20) begin
            if (busy8 === 1'b1) busy_n++;
            step();
            n++;
            if (s_valid8 === 1'b1 && nbits < 16) begin
                bits[nbits] = s_bit8;
                nbits++;
            end
        end
        check({tag, "_done_latency"}, 32'(n), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, "_sum"}, 32'(sum8), 32'(exp_sum));
        check({tag, "_carry"}, 32'(co8), 32'(exp_co));
        check({tag, "_serial_count"}, 32'(nbits), 32'd8);
        check({tag, "_serial_bits"}, 32'(bits), 32'(exp_sum));
        check({tag, "_busy_in_done"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        int n, gap;
        logic flag;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; ci3 = 1'b0;
        #12;
        check("rst_outs8", {26'd0, busy8, done8, co8, s_bit8, s_valid8, |sum8}, 32'd0);
        check("rst_outs3", {26'd0, busy3, done3, co3, s_bit3, s_valid3, |sum3}, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic add; LSB-first serial stream 0,1,1,0,1,0,0,1 == 0x96
        op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "a5a_3c");
        step();
        check("done_one_cycle", 32'(done8), 32'd0);
        // Idle hold with start low
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sum8 !== 8'h96 || busy8 !== 1'b0 || s_valid8 !== 1'b0 || done8 !== 1'b0) flag = 1'b1;
        end
        check("idle_hold_flags", 32'(flag), 32'd0);
        check("idle_hold_sum", 32'(sum8), 32'h96);

        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_01");
        step();
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_c1");
        step();
        op8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "zero_c1");
        step();

        // start held high; operands change during ADD; back-to-back second op
        a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0; start8 = 1'b1;
        step();
        a8 = 8'hF0; b8 = 8'h0F; ci8 = 1'b1;
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin step(); n++; end
        check("held_done_latency", 32'(n), 32'd8);
        check("held_sum1", 32'(sum8), 32'h33);
        check("held_co1", 32'(co8), 32'd0);
        a8 = 8'h40; b8 = 8'h05; ci8 = 1'b1;
        step();
        start8 = 1'b0;
        check("b2b_done_drop", 32'(done8), 32'd0);
        check("b2b_busy", 32'(busy8), 32'd1);
        check("b2b_sum_cleared", 32'(sum8), 32'd0);
        gap = 1;
        while (done8 !== 1'b1 && gap < 20) begin step(); gap++; end
        check("b2b_done_gap", 32'(gap), 32'd9);
        check("b2b_sum2", 32'(sum8), 32'h46);
        check("b2b_co2", 32'(co8), 32'd0);
        step();

        // Async reset mid-operation after 4 ADD cycles
        a8 = 8'h5A; b8 = 8'h3C; ci8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outs", {26'd0, busy8, done8, co8, s_bit8, s_valid8, |sum8}, 32'd0);
        #3 rst_n = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 !== 1'b0 || busy8 !== 1'b0) flag = 1'b1;
        end
        check("midrst_no_done", 32'(flag), 32'd0);
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after_rst");
        step();

        // Exhaustive 3-bit sweep
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a3 = 3'(ai); b3 = 3'(bi); ci3 = 1'(ci); start3 = 1'b1;
                    step();
                    start3 = 1'b0;
                    n = 0;
                    while (done3 !== 1'b1 && n < 10) begin step(); n++; end
                    check($sformatf("w3_%0d_%0d_%0d_lat", ai, bi, ci), 32'(n), 32'd3);
                    check($sformatf("w3_%0d_%0d_%0d_res", ai, bi, ci),
                          {28'd0, co3, sum3}, 32'(ai + bi + ci));
                    step();
                    check($sformatf("w3_%0d_%0d_%0d_pulse", ai, bi, ci), 32'(done3), 32'd0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
